// File: rtl/bow_tx_arbiter_if.sv
// bow_tx_arbiter_if: requester, link-partner and TX lane signals of the BoW TX arbiter.
interface bow_tx_arbiter_if;
    logic        rx_ready;
    logic        req0_valid, req0_last, req0_fec, req0_aux, req0_ready;
    logic [15:0] req0_data;
    logic        req1_valid, req1_last, req1_fec, req1_aux, req1_ready;
    logic [15:0] req1_data;
    logic [15:0] tx_data;
    logic        tx_valid, tx_last, tx_fec, tx_aux;
    logic [1:0]  grant;
    logic        busy, err_overlen;
    modport master (
        input  rx_ready,
        input  req0_valid, req0_last, req0_fec, req0_aux, req0_data,
        input  req1_valid, req1_last, req1_fec, req1_aux, req1_data,
        output req0_ready, req1_ready,
        output tx_data, tx_valid, tx_last, tx_fec, tx_aux, grant, busy, err_overlen
    );
    modport slave (
        output rx_ready,
        output req0_valid, req0_last, req0_fec, req0_aux, req0_data,
        output req1_valid, req1_last, req1_fec, req1_aux, req1_data,
        input  req0_ready, req1_ready,
        input  tx_data, tx_valid, tx_last, tx_fec, tx_aux, grant, busy, err_overlen
    );
endinterface

// File: rtl/bow_tx_arbiter.sv
// bow_tx_arbiter: round-robin burst arbiter of two requesters onto one BoW TX lane,
// with MAX_BURST truncation and a fixed idle gap after every burst.
module bow_tx_arbiter #(
    parameter int MAX_BURST  = 32,
    parameter int GAP_CYCLES = 2
) (
    input logic            txclk,
    input logic            presetn,
    bow_tx_arbiter_if.master b
);
    typedef enum logic [1:0] {IDLE, ARB, SEND, GAP} state_t;
    localparam logic [5:0]  MAX_CNT   = 6'(MAX_BURST);
    localparam logic [2:0]  GAP_LAST  = 3'(GAP_CYCLES - 1);
    localparam logic [15:0] IDLE_WORD = 16'h7FFE;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d, valid, ready;
    logic        rr_q, rr_d, win, acc, at_max, w_last, w_fec, w_aux;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  gap_q, gap_d;
    logic [15:0] w_data, tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic        tx_fec_q, tx_fec_d, tx_aux_q, tx_aux_d, err_q, err_d;

    always_comb begin
        valid      = {b.req1_valid, b.req0_valid};
        ready      = (state_q == SEND && b.rx_ready && presetn) ? grant_q : 2'b00;
        acc        = |(valid & ready);
        w_data     = grant_q[1] ? b.req1_data : b.req0_data;
        w_last     = grant_q[1] ? b.req1_last : b.req0_last;
        w_fec      = grant_q[1] ? b.req1_fec  : b.req0_fec;
        w_aux      = grant_q[1] ? b.req1_aux  : b.req0_aux;
        at_max     = (cnt_q + 6'd1) == MAX_CNT;
        win        = (&valid) ? rr_q : valid[1];
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tx_valid_d = acc;
        tx_last_d  = acc & (w_last | at_max);
        tx_fec_d   = acc & w_fec;
        tx_aux_d   = acc & w_aux;
        tx_data_d  = acc ? w_data : IDLE_WORD;
        err_d      = acc & at_max & ~w_last;
        case (state_q)
            IDLE: state_d = b.rx_ready ? ARB : IDLE;
            ARB: begin
                if (!b.rx_ready) begin
                    state_d = IDLE;
                end else if (|valid) begin
                    // priority moves away from the winner so each burst alternates under contention
                    grant_d = win ? 2'b10 : 2'b01;
                    rr_d    = ~win;
                    cnt_d   = 6'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (acc) begin
                    cnt_d = cnt_q + 6'd1;
                    if (w_last || at_max) begin
                        state_d = GAP;
                        grant_d = 2'b00;
                        gap_d   = 3'd0;
                    end
                end
            end
            GAP: begin
                gap_d = (gap_q == GAP_LAST) ? 3'd0 : gap_q + 3'd1;
                if (gap_q == GAP_LAST) state_d = b.rx_ready ? ARB : IDLE;
            end
        endcase
    end

    always_ff @(posedge txclk) begin
        if (!presetn) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            rr_q       <= 1'b0;
            cnt_q      <= 6'd0;
            gap_q      <= 3'd0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_fec_q   <= 1'b0;
            tx_aux_q   <= 1'b0;
            tx_data_q  <= IDLE_WORD;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_fec_q   <= tx_fec_d;
            tx_aux_q   <= tx_aux_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign b.req0_ready  = ready[0];
    assign b.req1_ready  = ready[1];
    assign b.tx_data     = tx_data_q;
    assign b.tx_valid    = tx_valid_q;
    assign b.tx_last     = tx_last_q;
    assign b.tx_fec      = tx_fec_q;
    assign b.tx_aux      = tx_aux_q;
    assign b.grant       = grant_q;
    assign b.busy        = (state_q == SEND) || (state_q == GAP);
    assign b.err_overlen = err_q;
endmodule

// File: doc/bow_tx_arbiter.md
BOW_TX_ARBITER -- requirements
Module: bow_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 32: maximum words per granted burst (range 1..32).
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted after each burst (range 1..7).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: txclk is the only clock; presetn is sampled only on posedge txclk.
REQ-004 txclk  in  1  sole clock; all state updates on posedge.
REQ-005 presetn  in  1  synchronous active-low reset.
REQ-006 rx_ready  in  1  link-partner ready; transfers are allowed only while high.
REQ-007 reqN_valid, reqN_last, reqN_fec, reqN_aux  in  1 each (N=0,1)  requester word qualifiers.
REQ-008 reqN_data  in  16  (N=0,1)  requester payload word.
REQ-009 reqN_ready  out  1  (N=0,1)  word accepted when reqN_valid & reqN_ready.
REQ-010 tx_data  out  16  registered word to the TX lane.
REQ-011 tx_valid, tx_last, tx_fec, tx_aux  out  1 each  registered qualifiers for tx_data.
REQ-012 grant  out  2  one-hot owner of the lane (01=req0, 10=req1, 00=none).
REQ-013 busy  out  1  high in SEND and GAP states.
REQ-014 err_overlen  out  1  one-cycle pulse when a burst is truncated at MAX_BURST.

Function
REQ-015 The FSM SHALL have the states IDLE, ARB, SEND and GAP, encoded in 2 bits.
REQ-016 IDLE SHALL go to ARB when rx_ready=1; otherwise it SHALL stay in IDLE.
REQ-017 ARB SHALL go to IDLE when rx_ready=0, and that check SHALL take priority over arbitration.
REQ-018 ARB SHALL, when any reqN_valid=1, register a grant and go to SEND on the next cycle.
REQ-019 ARB SHALL stay in ARB when no requester is valid.
REQ-020 Arbitration SHALL be round-robin per burst: rr_ptr favours one requester, and after a burst granted to N, rr_ptr SHALL favour the other requester.
REQ-021 When only one requester is valid in ARB, that requester SHALL win regardless of rr_ptr.
REQ-022 reqN_ready SHALL be combinational: (state==SEND) & grant[N] & rx_ready.
REQ-023 The non-granted reqN_ready SHALL always be 0.
REQ-024 On each accepted word, the block SHALL drive tx_data, tx_fec, tx_aux and tx_valid=1 on the next posedge (latency 1).
REQ-025 tx_last SHALL equal reqN_last of the accepted word, OR-ed with the MAX_BURST truncation condition.
REQ-026 In any cycle without an accepted word, the outputs SHALL be tx_valid=0, tx_last=0, tx_fec=0, tx_aux=0 and tx_data=16'h7FFE (idle word).
REQ-027 A 6-bit word counter SHALL clear on entry to SEND and increment per accepted word.
REQ-028 A burst SHALL end on the accepted word with reqN_last=1, or on the accepted word that brings the count to MAX_BURST.
REQ-029 On burst end, the FSM SHALL go to GAP, and grant SHALL become 00 on the same edge.
REQ-030 If the MAX_BURST-th word has reqN_last=0, tx_last SHALL be forced to 1 and err_overlen SHALL pulse for 1 cycle, aligned with that tx_valid.
REQ-031 When reqN_last=1 and the count hits MAX_BURST on the same word, the burst SHALL end normally with no err_overlen.
REQ-032 If rx_ready=0 during SEND, the block SHALL stall: no transfer, counter and grant held, no timeout; transfers resume when rx_ready returns to 1.
REQ-033 If the granted reqN_valid=0 during SEND, the block SHALL stall the same way.
REQ-034 GAP SHALL last exactly GAP_CYCLES cycles, counted by a 3-bit counter.
REQ-035 At the end of GAP, the FSM SHALL go to ARB if rx_ready=1, else to IDLE.
REQ-036 If rx_ready falls during GAP, the gap count SHALL still complete before the FSM leaves GAP.

Reset
REQ-037 While presetn=0 at posedge txclk, the block SHALL set state=IDLE, grant=00, rr_ptr favouring req0, and both counters to 0.
REQ-038 While presetn=0 at posedge txclk, the block SHALL set tx_valid=0, tx_last=0, tx_fec=0, tx_aux=0, tx_data=16'h7FFE, busy=0 and err_overlen=0.
REQ-039 While presetn=0, reqN_ready SHALL be 0.
REQ-040 Reset asserted mid-burst SHALL abandon the burst with no tx_last emitted; the first grant after reset SHALL go to req0 if both requesters are valid.

Verification
REQ-041 Reset then rx_ready=1, req0 sends 4 words A000..A003 with last on A003 -> tx_valid for 4 cycles, each 1 cycle after acceptance; tx_last with A003; then 2 GAP cycles with busy=1; then ARB.
REQ-042 Both requesters continuously valid with 3-word bursts -> grant order 01,10,01,10; no word interleaving within a burst.
REQ-043 req1 sends 40 words, never asserting last -> first burst truncated at 32 with tx_last=1 and err_overlen pulse; words 33..40 sent as the next req1 burst, or after req0 if req0 is valid.
REQ-044 rx_ready=0 for 5 cycles after word 2 of a 6-word burst -> req0_ready=0 during the stall; tx shows idle 7FFE; words 3..6 follow with no loss or duplication.
REQ-045 presetn=0 for 1 cycle after word 3 of req1's burst -> next cycle shows IDLE outputs, grant=00, no tx_last; with both requesters valid afterward, grant=01 first.
REQ-046 req0 valid with last=1 on its first word -> 1-word burst: tx_valid and tx_last together, no err_overlen.
